// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: phase-detector state encoding, default error width
// and the saturation constant used by both the phase detector and the loop filter.
package adpll_pkg;

    localparam int ERR_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REF_LEAD = 2'd1,
        FB_LEAD  = 2'd2
    } pec_state_t;

    // Largest magnitude representable in a signed word of width w.
    function automatic int sat_mag(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizer chain for an asynchronous clock-like input, followed by a
// registered rising-edge detector producing a single-cycle pulse.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic [STAGES-1:0] sync;
    logic              prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[STAGES-2:0], din};
            prev  <= sync[STAGES-1];
            pulse <= sync[STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/phase_error_counter.sv
// Counts clk cycles between matching ref/fb rising edges and emits a signed,
// saturated phase error with a strobe, bang-bang up/dn levels and a lock flag.
module phase_error_counter
    import adpll_pkg::*;
#(
    parameter int ERR_W       = ERR_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_COUNT  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    ref_in,
    input  logic                    fb_in,
    output logic signed [ERR_W-1:0] err,
    output logic                    err_valid,
    output logic                    up,
    output logic                    dn,
    output logic                    locked
);

    localparam int CNT_W = ERR_W - 1;
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]        SAT     = CNT_W'(sat_mag(ERR_W));
    localparam logic signed [ERR_W-1:0] SAT_POS = ERR_W'(sat_mag(ERR_W));
    localparam logic signed [ERR_W-1:0] TOL     = ERR_W'(LOCK_TOL);
    localparam logic [RUN_W-1:0]        RUN_MAX = RUN_W'(LOCK_COUNT);

    logic ref_e, fb_e;

    edge_sync #(.STAGES(SYNC_STAGES)) u_ref_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (ref_in),
        .pulse (ref_e)
    );

    edge_sync #(.STAGES(SYNC_STAGES)) u_fb_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (fb_in),
        .pulse (fb_e)
    );

    pec_state_t              state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic                    emit;
    logic signed [ERR_W-1:0] emit_val;
    logic signed [ERR_W-1:0] cnt_pos;

    assign cnt_pos = $signed({1'b0, cnt});

    // NOTE: every signal driven here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        emit     = 1'b0;
        emit_val = '0;
        case (state)
            IDLE: begin
                if (ref_e && fb_e) begin
                    emit = 1'b1;
                end else if (ref_e) begin
                    state_n = REF_LEAD;
                    cnt_n   = CNT_W'(1);
                end else if (fb_e) begin
                    state_n = FB_LEAD;
                    cnt_n   = CNT_W'(1);
                end
            end
            REF_LEAD: begin
                // Lagging edge wins over a slip or saturation in the same cycle.
                if (fb_e) begin
                    emit     = 1'b1;
                    emit_val = cnt_pos;
                    state_n  = IDLE;
                    cnt_n    = '0;
                end else if (ref_e) begin
                    emit     = 1'b1;
                    emit_val = SAT_POS;
                    cnt_n    = CNT_W'(1);
                end else if (cnt == SAT) begin
                    emit     = 1'b1;
                    emit_val = SAT_POS;
                    state_n  = IDLE;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            FB_LEAD: begin
                if (ref_e) begin
                    emit     = 1'b1;
                    emit_val = -cnt_pos;
                    state_n  = IDLE;
                    cnt_n    = '0;
                end else if (fb_e) begin
                    emit     = 1'b1;
                    emit_val = -SAT_POS;
                    cnt_n    = CNT_W'(1);
                end else if (cnt == SAT) begin
                    emit     = 1'b1;
                    emit_val = -SAT_POS;
                    state_n  = IDLE;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            emit    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            err       <= '0;
            err_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            err_valid <= emit;
            if (emit) begin
                err <= emit_val;
            end
        end
    end

    assign up = (state == REF_LEAD);
    assign dn = (state == FB_LEAD);

    // Lock tracking runs one cycle behind the strobe, on the registered error.
    logic [RUN_W-1:0] run, run_inc;
    logic             in_tol;

    assign in_tol  = (err <= TOL) && (err >= -TOL);
    assign run_inc = (run == RUN_MAX) ? run : run + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run    <= '0;
            locked <= 1'b0;
        end else if (!enable) begin
            run    <= '0;
            locked <= 1'b0;
        end else if (err_valid) begin
            if (in_tol) begin
                run    <= run_inc;
                locked <= (run_inc == RUN_MAX);
            end else begin
                run    <= '0;
                locked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_phase_error_counter.sv
// Directed bench for phase_error_counter: lead/lag measurements, saturation,
// cycle slip, lock acquisition/loss, reset and enable behaviour.
module tb_phase_error_counter;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              ref_in;
    logic              fb_in;
    logic signed [11:0] err;
    logic              err_valid;
    logic              up;
    logic              dn;
    logic              locked;

    phase_error_counter dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .ref_in    (ref_in),
        .fb_in     (fb_in),
        .err       (err),
        .err_valid (err_valid),
        .up        (up),
        .dn        (dn),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   nstrobe, nsat, nup, ndn, strobe_cyc, rise_cyc, fall_cyc, last_err;
    int   nboth = 0;
    logic prev_locked = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        nstrobe    = 0;
        nsat       = 0;
        nup        = 0;
        ndn        = 0;
        strobe_cyc = -1;
        rise_cyc   = -1;
        fall_cyc   = -1;
        last_err   = 9999;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (err_valid) begin
                nstrobe++;
                last_err   = err;
                strobe_cyc = cyc;
                if (err == 12'sd2047) nsat++;
            end
            if (up) nup++;
            if (dn) ndn++;
            if (up && dn) nboth++;
            if (locked && !prev_locked) rise_cyc = cyc;
            if (!locked && prev_locked) fall_cyc = cyc;
            prev_locked = locked;
        end
    endtask

    // d > 0: ref leads fb by d cycles; d < 0: fb leads by -d; d == 0: coincident.
    task automatic meas(input int d);
        clear_counts();
        if (d >= 0) ref_in = 1'b1;
        if (d <= 0) fb_in = 1'b1;
        if (d > 0) begin
            step(d);
            fb_in = 1'b1;
        end else if (d < 0) begin
            step(-d);
            ref_in = 1'b1;
        end
        step(12);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        step(8);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        ref_in = 1'b0;
        fb_in  = 1'b0;
        step(4);
        rst = 1'b0;
        step(4);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        ref_in = 1'b0;
        fb_in  = 1'b0;
        #1;
        check("rst_err", err, 0);
        check("rst_valid", err_valid, 0);
        check("rst_up", up, 0);
        check("rst_dn", dn, 0);
        check("rst_locked", locked, 0);
        step(3);
        rst = 1'b0;
        step(4);

        // Ref leads fb by 5 cycles.
        meas(5);
        check("t1_strobes", nstrobe, 1);
        check("t1_err", last_err, 5);
        check("t1_up_cycles", nup, 5);
        check("t1_dn_cycles", ndn, 0);

        // Fb leads ref by 3 cycles, then coincident edges.
        meas(-3);
        check("t2_strobes", nstrobe, 1);
        check("t2_err", last_err, -3);
        check("t2_dn_cycles", ndn, 3);
        check("t2_up_cycles", nup, 0);
        meas(0);
        check("t2_same_strobes", nstrobe, 1);
        check("t2_same_err", last_err, 0);
        check("t2_same_up", nup, 0);
        check("t2_same_dn", ndn, 0);

        // Ref high for a long time, fb stuck low: saturation after 2047 cycles.
        clear_counts();
        ref_in = 1'b1;
        step(2070);
        check("t3_sat_strobes", nstrobe, 1);
        check("t3_sat_err", last_err, 2047);
        check("t3_sat_up_cycles", nup, 2047);
        check("t3_sat_idle", up, 0);
        ref_in = 1'b0;
        step(5);

        // Ref period 100, fb stuck low: every ref edge after the first slips.
        clear_counts();
        for (int p = 0; p < 5; p++) begin
            ref_in = 1'b1;
            step(50);
            ref_in = 1'b0;
            step(50);
        end
        check("t3_slip_strobes", nstrobe, 4);
        check("t3_slip_sat", nsat, 4);
        check("t3_slip_still_lead", up, 1);
        check("t3_slip_dn", ndn, 0);
        do_reset();

        // Lock acquisition over 16 in-tolerance measurements, then loss.
        for (int k = 0; k < 15; k++) begin
            meas((k % 5) - 2);
        end
        check("t4_not_yet_locked", locked, 0);
        meas(1);
        check("t4_err16", last_err, 1);
        check("t4_lock_rise", rise_cyc, strobe_cyc + 1);
        check("t4_locked", locked, 1);
        meas(3);
        check("t4_err_out", last_err, 3);
        check("t4_lock_fall", fall_cyc, strobe_cyc + 1);
        check("t4_unlocked", locked, 0);

        // Reset in the middle of a ref-lead measurement at counter 40.
        clear_counts();
        ref_in = 1'b1;
        for (int w = 0; w < 20 && !up; w++) begin
            step(1);
        end
        check("t5_lead_started", up, 1);
        step(39);
        rst = 1'b1;
        #1;
        check("t5_rst_err", err, 0);
        check("t5_rst_valid", err_valid, 0);
        check("t5_rst_up", up, 0);
        check("t5_rst_dn", dn, 0);
        check("t5_no_strobe", nstrobe, 0);
        ref_in = 1'b0;
        step(3);
        rst = 1'b0;
        step(5);
        meas(7);
        check("t5_after_strobes", nstrobe, 1);
        check("t5_after_err", last_err, 7);

        // Enable dropped mid-measurement while locked, re-enabled with ref held high.
        for (int k = 0; k < 16; k++) begin
            meas(0);
        end
        check("t6_locked", locked, 1);
        clear_counts();
        ref_in = 1'b1;
        step(10);
        check("t6_lead", up, 1);
        enable = 1'b0;
        step(3);
        check("t6_dis_locked", locked, 0);
        check("t6_dis_up", up, 0);
        check("t6_dis_dn", dn, 0);
        step(5);
        enable = 1'b1;
        step(20);
        check("t6_no_strobe", nstrobe, 0);
        check("t6_no_false_edge", up, 0);
        check("t6_err_held", err, 0);
        ref_in = 1'b0;
        step(5);

        check("never_up_and_dn", nboth, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
